// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - Instruction cache control: fetch, one-cycle-late hit check, block refill, flush.
// Optional hit/miss counters are compiled in with ICACHE_PERF_COUNTERS_EN.

typedef struct packed {
  logic data;
  logic tag;
  logic valid;
} instruction_enable_t;

module icache_controller #(
  parameter int CACHE_SIZE = 8192,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                fetch_i,
  input  logic [31:0]         fetch_address_i,
  input  logic                fence_i,
  output logic                stall_o,
  output logic                instruction_valid_o,
  output logic                fence_done_o,
  output logic                load_request_o,
  output logic [31:0]         load_address_o,
  input  logic                load_valid_i,
  input  logic [31:0]         load_data_i,
  output logic [31:0]         cache_read_address_o,
  output instruction_enable_t cache_read_o,
  input  logic                cache_hit_i,
  output logic [31:0]         cache_write_address_o,
  output instruction_enable_t cache_write_o,
  output logic [31:0]         cache_instruction_o,
  output logic                cache_valid_o
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]         hit_count_o,
  output logic [31:0]         miss_count_o
`endif
);
  localparam int WORDS  = BLOCK_SIZE / 4;
  localparam int INDEX  = $clog2(CACHE_SIZE / BLOCK_SIZE);
  localparam int OFFSET = $clog2(BLOCK_SIZE);
  localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [INDEX-1:0]  LAST_INDEX = '1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORDS - 1);

  typedef enum logic [2:0] {FLUSH, IDLE, COMPARE, ALLOCATE, REFILL, REPLAY} state_e;

  state_e            state_q, state_d;
  logic [INDEX-1:0]  flush_cnt_q, flush_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              fence_pend_q, fence_pend_d;
  logic              fence_flush_q, fence_flush_d;

  logic        fetch_ok;
  logic        last_beat;
  logic [31:0] block_base;

  // A fence (live or pending) always wins over a fetch presented in the same cycle.
  assign fetch_ok   = fetch_i && !fence_i &&
                      ((state_q == IDLE) || (state_q == COMPARE && cache_hit_i && !fence_pend_q));
  assign last_beat  = (beat_cnt_q == LAST_BEAT);
  assign block_base = {addr_q[31:OFFSET], {OFFSET{1'b0}}};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= FLUSH;
      flush_cnt_q   <= '0;
      beat_cnt_q    <= '0;
      addr_q        <= '0;
      fence_pend_q  <= 1'b0;
      fence_flush_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      addr_q        <= addr_d;
      fence_pend_q  <= fence_pend_d;
      fence_flush_q <= fence_flush_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    addr_d        = fetch_ok ? fetch_address_i : addr_q;
    fence_pend_d  = fence_pend_q;
    fence_flush_d = fence_flush_q;
    case (state_q)
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (fence_i) begin
          flush_cnt_d   = '0;
          fence_flush_d = 1'b1;
        end else if (flush_cnt_q == LAST_INDEX) begin
          state_d       = IDLE;
          fence_flush_d = 1'b0;
        end
      end
      IDLE: begin
        if (fence_i) begin
          state_d       = FLUSH;
          flush_cnt_d   = '0;
          fence_flush_d = 1'b1;
        end else if (fetch_i) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (cache_hit_i) begin
          if (fence_i || fence_pend_q) begin
            state_d       = FLUSH;
            flush_cnt_d   = '0;
            fence_flush_d = 1'b1;
            fence_pend_d  = 1'b0;
          end else if (!fetch_i) begin
            state_d = IDLE;
          end
        end else begin
          state_d      = ALLOCATE;
          fence_pend_d = fence_pend_q | fence_i;
        end
      end
      ALLOCATE: begin
        state_d      = REFILL;
        beat_cnt_d   = '0;
        fence_pend_d = fence_pend_q | fence_i;
      end
      REFILL: begin
        fence_pend_d = fence_pend_q | fence_i;
        if (load_valid_i) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = REPLAY;
        end
      end
      REPLAY: begin
        fence_pend_d = fence_pend_q | fence_i;
        state_d      = COMPARE;
      end
      default: state_d = FLUSH;
    endcase
  end

  always_comb begin
    stall_o               = 1'b1;
    instruction_valid_o   = 1'b0;
    fence_done_o          = 1'b0;
    load_request_o        = 1'b0;
    load_address_o        = '0;
    cache_read_address_o  = '0;
    cache_read_o          = '0;
    cache_write_address_o = '0;
    cache_write_o         = '0;
    cache_instruction_o   = '0;
    cache_valid_o         = 1'b0;
    case (state_q)
      FLUSH: begin
        // Held off while reset is asserted so every output reads zero in reset.
        cache_write_o.valid   = rst_n_i;
        cache_write_address_o = 32'(flush_cnt_q) << OFFSET;
        fence_done_o          = fence_flush_q && (flush_cnt_q == LAST_INDEX) && !fence_i;
      end
      IDLE: stall_o = 1'b0;
      COMPARE: begin
        if (cache_hit_i) begin
          stall_o             = 1'b0;
          instruction_valid_o = 1'b1;
        end
      end
      ALLOCATE: begin
        load_request_o = 1'b1;
        load_address_o = block_base;
      end
      REFILL: begin
        if (load_valid_i) begin
          cache_write_o.data    = 1'b1;
          cache_write_address_o = block_base | (32'(beat_cnt_q) << 2);
          cache_instruction_o   = load_data_i;
          if (last_beat) begin
            cache_write_o.tag   = 1'b1;
            cache_write_o.valid = 1'b1;
            cache_valid_o       = 1'b1;
          end
        end
      end
      REPLAY: begin
        cache_read_o         = '1;
        cache_read_address_o = addr_q;
      end
      default: ;
    endcase
    if (fetch_ok) begin
      cache_read_o         = '1;
      cache_read_address_o = fetch_address_i;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic        replay_q, replay_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    replay_d     = (state_q == REPLAY);
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == COMPARE) begin
      if (cache_hit_i && !replay_q && hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
      if (!cache_hit_i && miss_count_q != '1)             miss_count_d = miss_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      replay_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      replay_q     <= replay_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// tb/tb_icache_controller.sv - Randomized scoreboard bench for icache_controller.
// Includes a direct-mapped cache array model and a block memory responder.

module tb_icache_controller;
  localparam int WORDS = 4;
  localparam int NIDX  = 512;
  localparam int W_DATA = 2, W_TAG = 1, W_VALID = 0;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        fetch_i = 1'b0;
  logic [31:0] fetch_address_i = '0;
  logic        fence_i = 1'b0;
  logic        stall_o, instruction_valid_o, fence_done_o, load_request_o;
  logic [31:0] load_address_o;
  logic        load_valid_i;
  logic [31:0] load_data_i;
  logic [31:0] cache_read_address_o;
  logic [2:0]  cache_read_o;
  logic        cache_hit_i;
  logic [31:0] cache_write_address_o;
  logic [2:0]  cache_write_o;
  logic [31:0] cache_instruction_o;
  logic        cache_valid_o;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_o, miss_count_o;
`endif

  icache_controller dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .fetch_i(fetch_i), .fetch_address_i(fetch_address_i),
    .fence_i(fence_i), .stall_o(stall_o), .instruction_valid_o(instruction_valid_o),
    .fence_done_o(fence_done_o), .load_request_o(load_request_o), .load_address_o(load_address_o),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .cache_read_address_o(cache_read_address_o), .cache_read_o(cache_read_o),
    .cache_hit_i(cache_hit_i), .cache_write_address_o(cache_write_address_o),
    .cache_write_o(cache_write_o), .cache_instruction_o(cache_instruction_o),
    .cache_valid_o(cache_valid_o)
`ifdef ICACHE_PERF_COUNTERS_EN
    , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h00A0} + 32'(a[3:2]);
  endfunction

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 7)) << 4) |
           32'($urandom_range(0, 15));
  endfunction

  // Reference: which block each index should hold, in spec terms.
  typedef struct { logic [31:0] addr; bit miss; int cyc; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] miss_q[$];
  bit          res_v [NIDX];
  logic [18:0] res_t [NIDX];
  int          nhit = 0, nmiss = 0, fences = 0, done_cnt = 0;
  bit          fence_flush_exp = 0;
  int          flush_writes = 0;

  // Cache array model: stale contents at start, hit reported one cycle after the read.
  bit          cm_v [NIDX];
  logic [18:0] cm_t [NIDX];
  bit          rd_pend;
  logic [31:0] rd_addr;
  initial begin
    cache_hit_i = 1'b0;
    for (int i = 0; i < NIDX; i++) begin
      cm_v[i] = 1'($urandom);
      cm_t[i] = 19'($urandom_range(0, 3));
    end
    forever begin
      @(negedge clk_i);
      if (cache_write_o[W_VALID]) cm_v[cache_write_address_o[12:4]] = cache_valid_o;
      if (cache_write_o[W_TAG])   cm_t[cache_write_address_o[12:4]] = cache_write_address_o[31:13];
      rd_pend = cache_read_o[W_DATA];
      rd_addr = cache_read_address_o;
      @(posedge clk_i);
      #1;
      cache_hit_i = rd_pend && cm_v[rd_addr[12:4]] && (cm_t[rd_addr[12:4]] == rd_addr[31:13]);
    end
  end

  // Memory responder: beats with idle gaps, stray valids when no refill is outstanding.
  bit          refill_go = 0, beat_now = 0;
  logic [31:0] refill_base;
  int          beat_i = 0, gap = 0, gap_mode = -1;
  initial begin
    load_valid_i = 1'b0;
    load_data_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (refill_go && gap > 0) begin
        load_valid_i = 1'b0;
        beat_now     = 0;
        gap--;
      end else if (refill_go) begin
        load_valid_i = 1'b1;
        load_data_i  = mem_word(refill_base + 32'(beat_i * 4));
        beat_now     = 1;
        beat_i++;
        gap = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
        if (beat_i == WORDS) refill_go = 0;
      end else begin
        beat_now     = 0;
        load_valid_i = ($urandom_range(0, 9) == 0);
        load_data_i  = $urandom;
      end
    end
  end

  // Monitor
  bit          refill_seen = 0, prev_rd_v = 0;
  logic [31:0] prev_rd_addr = '0, cur_base = '0;
  int          wr_beat = 0, flush_idx = 0;
  initial begin
    exp_t e;
    bit   flush_wr, at_end;
    forever begin
      @(negedge clk_i);
      if (rst_n_i) begin
        if (load_request_o) begin
          if (miss_q.size() == 0) begin
            total++; bad++;
            $display("FAIL load_request: unexpected request addr %h", load_address_o);
          end else begin
            cur_base = miss_q.pop_front();
            check("load_address", load_address_o, cur_base);
          end
          refill_seen = 1;
          wr_beat     = 0;
          refill_base = cur_base;
          beat_i      = 0;
          gap         = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
          refill_go   = 1;
        end
        check("write_on_beat", 32'(cache_write_o[W_DATA]), 32'(beat_now));
        if (cache_write_o[W_DATA]) begin
          check("write_addr", cache_write_address_o, cur_base + 32'(wr_beat * 4));
          check("write_data", cache_instruction_o, mem_word(cur_base + 32'(wr_beat * 4)));
          check("tag_valid", {29'd0, cache_write_o[W_TAG], cache_write_o[W_VALID], cache_valid_o},
                (wr_beat == WORDS - 1) ? 32'd7 : 32'd0);
          wr_beat++;
        end
        flush_wr = cache_write_o[W_VALID] && !cache_write_o[W_DATA];
        at_end   = flush_wr && (flush_idx == NIDX - 1);
        if (flush_wr) begin
          check("flush_addr", cache_write_address_o, 32'(flush_idx) << 4);
          check("flush_fields", {30'd0, cache_write_o[W_TAG], cache_valid_o}, 32'd0);
        end
        if (at_end || fence_done_o) begin
          check("fence_done", 32'(fence_done_o), 32'(at_end && fence_flush_exp));
          fence_flush_exp = 0;
        end
        if (flush_wr) begin
          flush_idx = (flush_idx + 1) % NIDX;
          flush_writes++;
        end
        if (fence_done_o) done_cnt++;
        if (load_request_o || cache_write_o != 3'b000) check("stall_busy", 32'(stall_o), 32'd1);
        if (instruction_valid_o) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL deliver: unexpected instruction_valid_o for %h", prev_rd_addr);
          end else begin
            e = exp_q.pop_front();
            check("deliver_read", 32'(prev_rd_v), 32'd1);
            check("deliver_addr", prev_rd_addr, e.addr);
            check("deliver_miss", 32'(refill_seen), 32'(e.miss));
            if (!e.miss) check("hit_latency", 32'(cyc - e.cyc), 32'd1);
          end
          refill_seen = 0;
        end
        prev_rd_v = cache_read_o[W_DATA];
        if (cache_read_o[W_DATA]) prev_rd_addr = cache_read_address_o;
      end
    end
  end

  task automatic accept(input logic [31:0] a);
    bit hit;
    hit = res_v[a[12:4]] && (res_t[a[12:4]] == a[31:13]);
    if (!hit) begin
      miss_q.push_back({a[31:4], 4'h0});
      res_v[a[12:4]] = 1;
      res_t[a[12:4]] = a[31:13];
      nmiss++;
    end else begin
      nhit++;
    end
    exp_q.push_back('{addr: a, miss: !hit, cyc: cyc});
  endtask

  task automatic do_fetch(input logic [31:0] a, output int waits);
    waits = 0;
    @(posedge clk_i);
    #2;
    fetch_i = 1'b1;
    fence_i = 1'b0;
    fetch_address_i = a;
    forever begin
      @(negedge clk_i);
      if (!stall_o) break;
      waits++;
      if (waits > 300) begin
        total++; bad++;
        $display("FAIL fetch_timeout: %h still stalled", a);
        return;
      end
      @(posedge clk_i);
      #2;
    end
    accept(a);
  endtask

  task automatic idle();
    @(posedge clk_i);
    #2;
    fetch_i = 1'b0;
    fence_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_fence(input bit with_fetch, input logic [31:0] a);
    int n;
    @(posedge clk_i);
    #2;
    fence_i = 1'b1;
    fetch_i = with_fetch;
    fetch_address_i = a;
    fence_flush_exp = 1;
    fences++;
    @(negedge clk_i);
    if (with_fetch) check("fenced_fetch_read", 32'(cache_read_o), 32'd0);
    for (int i = 0; i < NIDX; i++) res_v[i] = 0;
    @(posedge clk_i);
    #2;
    fence_i = 1'b0;
    fetch_i = 1'b0;
    n = 0;
    while (done_cnt < fences) begin
      @(negedge clk_i);
      n++;
      if (n > 3000) begin
        total++; bad++;
        $display("FAIL fence_timeout: done=%0d expected %0d", done_cnt, fences);
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || miss_q.size() != 0) begin
      idle();
      n++;
      if (n > 500) begin
        total++; bad++;
        $display("FAIL drain_timeout: pending=%0d misses=%0d", exp_q.size(), miss_q.size());
        break;
      end
    end
  endtask

  initial begin
    repeat (60000) @(posedge clk_i);
    total++; bad++;
    $display("FAIL watchdog: run exceeded cycle budget");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n, w, r;
    bit last_fetch;
    for (int i = 0; i < NIDX; i++) res_v[i] = 0;
    #1 rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_stall", 32'(stall_o), 32'd1);
    check("reset_outputs_zero",
          32'(|{instruction_valid_o, fence_done_o, load_request_o, load_address_o,
                cache_read_address_o, cache_read_o, cache_write_address_o, cache_write_o,
                cache_instruction_o, cache_valid_o}), 32'd0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (!stall_o) break;
      n++;
      if (n > 2000) break;
    end
    check("reset_flush_cycles", n, 512);
    check("reset_flush_writes", flush_writes, 512);
    check("reset_no_done", done_cnt, 0);

    gap_mode = 3;
    do_fetch(32'h0000_1004, w);
    wait_drain();
    gap_mode = -1;
    do_fetch(32'h0000_1000, w);
    check("b2b_wait0", w, 0);
    do_fetch(32'h0000_1004, w);
    check("b2b_wait1", w, 0);
    do_fetch(32'h0000_1008, w);
    check("b2b_wait2", w, 0);
    wait_drain();

    gap_mode = 3;
    do_fetch(32'h0000_2004, w);
    n = 0;
    while (!refill_go && n < 50) begin
      idle();
      n++;
    end
    idle();
    idle();
    do_fence(0, 32'h0);
    wait_drain();
    gap_mode = -1;
    do_fetch(32'h0000_1004, w);
    wait_drain();
    do_fence(1, 32'h0000_1008);
    wait_drain();

    last_fetch = 0;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_fence(last_fetch && ($urandom_range(0, 1) == 1), rand_addr());
        last_fetch = 0;
      end else if (r < 75) begin
        do_fetch(rand_addr(), w);
        last_fetch = 1;
      end else begin
        idle();
        last_fetch = 0;
      end
    end
    wait_drain();
    repeat (5) idle();
    check("fence_done_total", done_cnt, fences);
    check("scoreboard_empty", exp_q.size() + miss_q.size(), 0);
`ifdef ICACHE_PERF_COUNTERS_EN
    check("hit_count", hit_count_o, nhit);
    check("miss_count", miss_count_o, nmiss);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Control stage directly upstream of the instruction cache arrays.
- Accepts fetch requests from the fetch unit and drives the cache read port.
- Checks the one-cycle-late hit. On a miss, refills the whole block from the memory bus through the cache write port, then replays the read.
- Also owns invalidation: a full flush after reset and on fence.i.

Parameters:
- CACHE_SIZE, 8192, total cache size in bytes; must match the cache array.
- BLOCK_SIZE, 16, block size in bytes, power of two ≥4. WORDS = BLOCK_SIZE/4.
- INDEX (derived), log2(CACHE_SIZE/BLOCK_SIZE), number of index bits.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- fetch_i  in  1  fetch request; sampled only when stall_o=0
- fetch_address_i  in  32  instruction address, bits [1:0] ignored
- fence_i  in  1  flush request (fence.i), one-cycle pulse
- stall_o  out  1  controller busy; fetch_i not accepted
- instruction_valid_o  out  1  cache_instruction_i (cache output) is valid this cycle
- fence_done_o  out  1  one-cycle pulse when a fence-requested flush completes
- load_request_o  out  1  one-cycle memory request
- load_address_o  out  32  block-aligned refill address (low log2(BLOCK_SIZE) bits zero)
- load_valid_i  in  1  refill beat valid
- load_data_i  in  32  refill word; beats arrive in ascending address order
- cache_read_address_o  out  32  to cache read_address_i
- cache_read_o  out  instruction_enable_t  to cache read_i; data/valid/tag driven together
- cache_hit_i  in  1  from cache hit_o; refers to the read issued the previous cycle
- cache_write_address_o  out  32  to cache write_address_i
- cache_write_o  out  instruction_enable_t  to cache write_i
- cache_instruction_o  out  32  to cache instruction_i
- cache_valid_o  out  1  to cache valid_i

Behaviour:
- Reset (async, active low):
  - State = FLUSH, flush counter = 0.
  - All outputs 0 except stall_o = 1.
  - The valid memory is not reset, so the post-reset flush is mandatory. It takes 2^INDEX cycles and does not pulse fence_done_o.
- States: FLUSH, IDLE, COMPARE, ALLOCATE, REFILL, REPLAY.
- FLUSH:
  - Each cycle: cache_write_o.valid = 1 (data/tag = 0), cache_valid_o = 0, write index = counter; counter++.
  - On the last index, go to IDLE. Pulse fence_done_o if the flush was fence-initiated.
  - stall_o = 1 throughout.
- IDLE:
  - fence_i → FLUSH; fence_i has priority over a simultaneous fetch_i, which is dropped.
  - fetch_i → drive all cache_read_o fields, cache_read_address_o = fetch_address_i, latch the address, go to COMPARE.
- COMPARE:
  - cache_hit_i = 1 → instruction_valid_o = 1.
    - A new fetch_i this cycle is accepted back-to-back: read issued, stay in COMPARE. Throughput is 1 fetch/cycle, latency 1 cycle.
    - Otherwise go to IDLE.
    - fence_i on a hit cycle → FLUSH; any fetch_i that cycle is dropped.
  - cache_hit_i = 0 → stall_o = 1 (combinationally this cycle), go to ALLOCATE. A new fetch_i presented that cycle is not accepted.
- ALLOCATE:
  - load_request_o = 1 for exactly one cycle.
  - load_address_o = latched address with low log2(BLOCK_SIZE) bits cleared.
  - Beat counter = 0, go to REFILL.
- REFILL:
  - Wait indefinitely for beats.
  - On each load_valid_i: cache_write_o.data = 1, cache_write_address_o = base + 4*counter, cache_instruction_o = load_data_i, counter++.
  - On beat WORDS-1: additionally cache_write_o.tag = 1, cache_write_o.valid = 1, cache_valid_o = 1; go to REPLAY.
- REPLAY: reissue the read of the latched address, go to COMPARE. The hit is guaranteed.
- fence_i arriving in ALLOCATE/REFILL/REPLAY/COMPARE-miss:
  - Recorded in a pending flag and never lost.
  - Taken after the replay hit completes: COMPARE → FLUSH instead of IDLE.
  - The replayed instruction is still delivered.
- fence_i during FLUSH: restarts the counter at 0.
- Stray load_valid_i outside REFILL: ignored.
- stall_o = 1 in every state except IDLE and COMPARE-with-hit.
- Reset mid-refill: aborts immediately. Remaining beats are ignored because the state is FLUSH.

Optional Feature:
- Macro: ICACHE_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs hit_count_o [31:0] and miss_count_o [31:0], reset to 0, saturating at 0xFFFFFFFF.
  - hit_count_o increments on each COMPARE hit that is not a replay.
  - miss_count_o increments on each COMPARE miss.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Release reset → stall_o = 1 for exactly 512 cycles (defaults), 512 valid-clear writes to indices 0..511, then stall_o = 0, fence_done_o never pulsed.
- Fetch 0x0000_1004 on a cold cache, respond 4 beats 0xA0..0xA3 → load_address_o = 0x0000_1000, writes to 0x1000/1004/1008/100C, tag+valid only on the 4th beat, then replay, instruction_valid_o = 1 with hit.
- After the refill, fetch 0x1000, 0x1004, 0x1008 on consecutive cycles → three instruction_valid_o pulses on consecutive cycles, no stall.
- Refill beats spaced 3 idle cycles apart → writes occur only on load_valid_i cycles, counter advances correctly, stall_o held high.
- fence_i during REFILL → refill completes, replay delivered, then 512-cycle flush, fence_done_o pulse; a re-fetch of 0x1004 misses.
- fence_i and fetch_i in the same IDLE cycle → flush taken, fetch dropped, no cache read issued.
